// File: rtl/seq_lut_loader.sv
// seq_lut_loader: loads the sequencer LUT from a host entry stream, with optional readback checksum verify
module seq_lut_loader #(
  parameter int ENTRY_W    = 37,
  parameter int DEPTH      = 256,
  parameter int RST_CYCLES = 4,
  parameter int READ_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               cfg_start_i,
  input  logic [8:0]         cfg_num_entries_i,
  input  logic               verify_en_i,
  input  logic               abort_i,
  input  logic               entry_valid_i,
  input  logic [ENTRY_W-1:0] entry_data_i,
  output logic               entry_ready_o,
  output logic               seq_reset_o,
  output logic               lut_wen_o,
  output logic [ENTRY_W-1:0] lut_write_data_o,
  output logic               lut_rden_o,
  input  logic [ENTRY_W-1:0] lut_read_data_i,
  output logic               config_done_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [8:0]         entries_written_o
);
  typedef enum logic [2:0] {IDLE, HOLD, WRITE, REWIND, VERIFY, CHECK, FINISH} state_t;
  localparam int CW = $clog2(RST_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [8:0] n, issued, returned;
  logic v, cd_q, err_q, wen_q, start, hs, rst_done, rvalid;
  logic [ENTRY_W-1:0] wdata_q, wr_sum, rd_sum;
  logic [READ_LAT-1:0] pipe;
  assign start = (state == IDLE) && cfg_start_i;
  assign entry_ready_o = (state == WRITE) && (entries_written_o < n);
  assign hs = entry_ready_o && entry_valid_i && !abort_i;
  assign rst_done = cnt == CW'(RST_CYCLES - 1);
  assign rvalid = pipe[READ_LAT-1];
  assign seq_reset_o = (state == HOLD) || (state == REWIND);
  assign lut_wen_o = wen_q;
  assign lut_write_data_o = wdata_q;
  assign lut_rden_o = (state == VERIFY) && (issued < n);
  assign busy_o = state != IDLE;
  assign done_o = state == FINISH;
  assign config_done_o = cd_q | done_o;
  assign error_o = err_q;
  // state register
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_nx;
  // next-state: abort from any busy state wins over normal progress
  always_comb begin
    state_nx = state;
    if (busy_o && abort_i) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = cfg_start_i ? HOLD : IDLE;
        HOLD:    state_nx = rst_done ? ((n == 9'd0) ? FINISH : WRITE) : HOLD;
        WRITE:   state_nx = (entries_written_o == n) ? (v ? REWIND : FINISH) : WRITE;
        REWIND:  state_nx = rst_done ? VERIFY : REWIND;
        VERIFY:  state_nx = (returned == n) ? CHECK : VERIFY;
        CHECK:   state_nx = (rd_sum == wr_sum) ? FINISH : IDLE;
        default: state_nx = IDLE;
      endcase
  end
  // datapath: reset counter, registered write strobe, read return pipe, checksums and status
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) begin
      cnt <= '0;
      n <= '0;
      v <= 1'b0;
      issued <= '0;
      returned <= '0;
      cd_q <= 1'b0;
      err_q <= 1'b0;
      wen_q <= 1'b0;
      wdata_q <= '0;
      wr_sum <= '0;
      rd_sum <= '0;
      pipe <= '0;
      entries_written_o <= '0;
    end else begin
      cnt <= (seq_reset_o && !rst_done) ? cnt + 1'b1 : '0;
      wen_q <= hs;
      pipe <= READ_LAT'({pipe, lut_rden_o});
      if (hs) begin
        wdata_q <= entry_data_i;
        entries_written_o <= entries_written_o + 9'd1;
        wr_sum <= wr_sum + (entry_data_i ^ ENTRY_W'(entries_written_o));
      end
      if (lut_rden_o) issued <= issued + 9'd1;
      if (rvalid) begin
        returned <= returned + 9'd1;
        rd_sum <= rd_sum + (lut_read_data_i ^ ENTRY_W'(returned));
      end
      if (start) begin
        n <= (cfg_num_entries_i > 9'(DEPTH)) ? 9'(DEPTH) : cfg_num_entries_i;
        v <= verify_en_i;
        issued <= '0;
        returned <= '0;
        cd_q <= 1'b0;
        err_q <= 1'b0;
        wr_sum <= '0;
        rd_sum <= '0;
        entries_written_o <= '0;
      end
      if (state == CHECK && rd_sum != wr_sum) err_q <= 1'b1;
      if (state == FINISH && !abort_i) cd_q <= 1'b1;
      if (busy_o && abort_i) begin
        err_q <= 1'b1;
        wen_q <= 1'b0;
        pipe <= '0;
      end
    end
endmodule
